// File: rtl/led_pattern_sequencer.sv
// Purpose: advance an LED pattern (blink/bounce/count/hold) on each rising edge
//          of a slow divided clock, then gate it with a PWM brightness mask.
// Latency: pattern updates 3 clk edges after step_in rises; led lags pattern by 1 cycle.
// Backpressure: none; steps seen while disabled or during a mode change are dropped.
//
// Ports:
//   clk         fast system clock, rising-edge active
//   rst         asynchronous active-high reset
//   step_in     slow divided clock, asynchronous to clk
//   enable      1 = advance pattern and drive LEDs, 0 = freeze pattern, LEDs dark
//   mode        00 BLINK, 01 SHIFT (bounce), 10 COUNT, 11 HOLD
//   brightness  PWM duty code (all-ones = 100%)
//   pattern     registered pattern before the PWM mask
//   led         registered pattern ANDed with the PWM mask
//   step_tick   one-cycle pulse in the cycle after each accepted step
module led_pattern_sequencer #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_in,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] pattern,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_tick
);

    localparam int POS_W = $clog2(NUM_LEDS);

    typedef enum logic [1:0] {
        MODE_BLINK = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_COUNT = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] ONE_HOT0 = NUM_LEDS'(1);

    logic                s1, s2, s3;
    logic [1:0]          mode_q;
    logic [POS_W-1:0]    pos, pos_nxt;
    logic                dir_down, dir_down_nxt;
    logic [NUM_LEDS-1:0] pattern_nxt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                step_edge;
    logic                mode_change;
    logic                accept;
    logic                on_mask;

    // s1 is the metastability stage; s2/s3 form the rising-edge detector.
    assign step_edge   = s2 & ~s3;
    assign mode_change = (mode != mode_q);
    // A step coinciding with a mode change is dropped in favour of the reinit.
    assign accept      = step_edge & enable & ~mode_change;
    // All-ones brightness means full duty; the compare alone would top out one short.
    assign on_mask     = (&brightness) | (pwm_cnt < brightness);

    always_comb begin
        pattern_nxt  = pattern;
        pos_nxt      = pos;
        dir_down_nxt = dir_down;
        if (mode_change) begin
            case (mode_t'(mode))
                MODE_BLINK: pattern_nxt = '0;
                MODE_SHIFT: begin
                    pattern_nxt  = ONE_HOT0;
                    pos_nxt      = '0;
                    dir_down_nxt = 1'b0;
                end
                MODE_COUNT: pattern_nxt = '0;
                default:    pattern_nxt = pattern;
            endcase
        end else if (accept) begin
            case (mode_t'(mode))
                MODE_BLINK: pattern_nxt = ~pattern;
                MODE_SHIFT: begin
                    // Direction flips on arriving at an end, so the end LED
                    // is lit for one step only and never repeats.
                    if (!dir_down) begin
                        pos_nxt = pos + POS_W'(1);
                        if (pos_nxt == POS_LAST) dir_down_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos - POS_W'(1);
                        if (pos_nxt == '0) dir_down_nxt = 1'b0;
                    end
                    pattern_nxt = ONE_HOT0 << pos_nxt;
                end
                MODE_COUNT: pattern_nxt = pattern + NUM_LEDS'(1);
                default:    pattern_nxt = pattern;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            mode_q    <= 2'b00;
            pattern   <= '0;
            pos       <= '0;
            dir_down  <= 1'b0;
            step_tick <= 1'b0;
            pwm_cnt   <= '0;
            led       <= '0;
        end else begin
            s1        <= step_in;
            s2        <= s1;
            s3        <= s2;
            mode_q    <= mode;
            pattern   <= pattern_nxt;
            pos       <= pos_nxt;
            dir_down  <= dir_down_nxt;
            step_tick <= accept;
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            led       <= enable ? (pattern & {NUM_LEDS{on_mask}}) : '0;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Purpose: directed self-checking bench for led_pattern_sequencer (8 LEDs, 4-bit PWM).
// Latency: inputs driven and outputs sampled 1 time unit after each rising clk edge.
// Backpressure: n/a; every wait is a fixed number of clock cycles.
module tb_led_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_in;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] brightness;
    logic [7:0] pattern;
    logic [7:0] led;
    logic       step_tick;

    int checks = 0;
    int errors = 0;

    led_pattern_sequencer #(.NUM_LEDS(8), .PWM_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_in    (step_in),
        .enable     (enable),
        .mode       (mode),
        .brightness (brightness),
        .pattern    (pattern),
        .led        (led),
        .step_tick  (step_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       enable;
        logic [7:0] exp_pattern;
        logic       exp_tick;
    } step_vec_t;

    typedef struct {
        logic [3:0] brightness;
        logic       enable;
        int         exp_count;
    } pwm_vec_t;

    step_vec_t step_tab[12];
    pwm_vec_t  pwm_tab[7];
    logic [7:0] shift_exp[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full step_in pulse; samples outputs right after the edge that applies the step.
    task automatic do_step(output logic [7:0] pat, output logic tk, output logic [7:0] ld);
        step_in = 1'b1;
        repeat (3) tick();
        pat = pattern;
        tk  = step_tick;
        ld  = led;
        step_in = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] p, l;
        logic       t;
        int         cnt, bad;

        // Mixed-mode step table, starting from BLINK with pattern 0xFF.
        step_tab[0]  = '{2'b00, 1'b1, 8'h00, 1'b1};
        step_tab[1]  = '{2'b00, 1'b1, 8'hFF, 1'b1};
        step_tab[2]  = '{2'b11, 1'b1, 8'hFF, 1'b1};
        step_tab[3]  = '{2'b11, 1'b0, 8'hFF, 1'b0};
        step_tab[4]  = '{2'b10, 1'b1, 8'h01, 1'b1};
        step_tab[5]  = '{2'b10, 1'b1, 8'h02, 1'b1};
        step_tab[6]  = '{2'b10, 1'b0, 8'h02, 1'b0};
        step_tab[7]  = '{2'b10, 1'b0, 8'h02, 1'b0};
        step_tab[8]  = '{2'b10, 1'b0, 8'h02, 1'b0};
        step_tab[9]  = '{2'b10, 1'b1, 8'h03, 1'b1};
        step_tab[10] = '{2'b00, 1'b1, 8'hFF, 1'b1};
        step_tab[11] = '{2'b01, 1'b1, 8'h02, 1'b1};

        pwm_tab[0] = '{4'd0,  1'b1, 0};
        pwm_tab[1] = '{4'd4,  1'b1, 4};
        pwm_tab[2] = '{4'd15, 1'b1, 16};
        pwm_tab[3] = '{4'd8,  1'b1, 8};
        pwm_tab[4] = '{4'd1,  1'b1, 1};
        pwm_tab[5] = '{4'd14, 1'b1, 14};
        pwm_tab[6] = '{4'd15, 1'b0, 0};

        shift_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                      8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        // 1. Reset and step latency
        rst = 1'b1; step_in = 1'b0; enable = 1'b1; mode = 2'b00; brightness = 4'd15;
        repeat (3) tick();
        check("rst_pattern", pattern, 8'h00);
        check("rst_led", led, 8'h00);
        check("rst_tick", step_tick, 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        step_in = 1'b1;
        tick();
        check("lat_e1_pattern", pattern, 8'h00);
        tick();
        check("lat_e2_pattern", pattern, 8'h00);
        tick();
        check("lat_e3_pattern", pattern, 8'hFF);
        check("lat_e3_tick", step_tick, 1'b1);
        cnt = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_tick) cnt++;
            if (pattern !== 8'hFF) bad++;
        end
        check("hold_high_ticks", cnt, 0);
        check("hold_high_changes", bad, 0);
        check("led_after_step", led, 8'hFF);
        step_in = 1'b0;
        repeat (3) tick();

        // 4. PWM duty on led[0] over one full counter period
        foreach (pwm_tab[k]) begin
            brightness = pwm_tab[k].brightness;
            enable     = pwm_tab[k].enable;
            cnt = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (led[0]) cnt++;
            end
            check($sformatf("pwm_duty_b%0d_en%0d", pwm_tab[k].brightness, pwm_tab[k].enable),
                  cnt, pwm_tab[k].exp_count);
        end
        enable = 1'b1; brightness = 4'd15;
        tick();

        // Mixed-mode step table (blink, hold, enable gating, no replay, reinit)
        foreach (step_tab[k]) begin
            mode   = step_tab[k].mode;
            enable = step_tab[k].enable;
            do_step(p, t, l);
            check($sformatf("tab%0d_pattern", k), p, step_tab[k].exp_pattern);
            check($sformatf("tab%0d_tick", k), t, step_tab[k].exp_tick);
            if (!step_tab[k].enable) check($sformatf("tab%0d_led_dark", k), l, 8'h00);
        end

        // 2. SHIFT bounce from a fresh reinit
        enable = 1'b1;
        mode = 2'b00; repeat (2) tick();
        mode = 2'b01; repeat (2) tick();
        check("shift_reinit", pattern, 8'h01);
        foreach (shift_exp[k]) begin
            do_step(p, t, l);
            check($sformatf("shift_step%0d", k + 1), p, shift_exp[k]);
        end

        // 3. COUNT wrap
        mode = 2'b10; repeat (2) tick();
        check("count_reinit", pattern, 8'h00);
        bad = 0;
        for (int i = 1; i <= 257; i++) begin
            do_step(p, t, l);
            if (p !== 8'(i) || t !== 1'b1) bad++;
            if (i == 255) check("count_255", p, 8'hFF);
            if (i == 256) check("count_256", p, 8'h00);
            if (i == 257) check("count_257", p, 8'h01);
        end
        check("count_sequence_errors", bad, 0);

        // 5. Mode change coincident with step_edge
        mode = 2'b01; repeat (2) tick();
        mode = 2'b10; repeat (2) tick();
        for (int i = 0; i < 5; i++) do_step(p, t, l);
        check("mc_pre_pattern", pattern, 8'h05);
        step_in = 1'b1;
        repeat (2) tick();
        mode = 2'b01;
        tick();
        check("mc_pattern", pattern, 8'h01);
        check("mc_no_tick", step_tick, 1'b0);
        step_in = 1'b0;
        repeat (3) tick();
        do_step(p, t, l);
        check("mc_next_pattern", p, 8'h02);
        check("mc_next_tick", t, 1'b1);

        // 6. Asynchronous reset mid-SHIFT at 0x10
        do_step(p, t, l);
        do_step(p, t, l);
        step_in = 1'b1;
        repeat (3) tick();
        check("pre_rst_pattern", pattern, 8'h10);
        check("pre_rst_tick", step_tick, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pattern", pattern, 8'h00);
        check("async_rst_led", led, 8'h00);
        check("async_rst_tick", step_tick, 1'b0);
        tick();
        rst = 1'b0;
        // step_in still high at release: mode reinit at e1, one step at e3.
        tick();
        check("rel_e1_pattern", pattern, 8'h01);
        tick();
        tick();
        check("rel_e3_pattern", pattern, 8'h02);
        check("rel_e3_tick", step_tick, 1'b1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_tick) cnt++;
        end
        check("rel_single_step", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Consumes the slow toggling square wave from the clock divider and advances an LED pattern once per rising edge of that wave.
- Four pattern modes: blink, bounce, count, hold.
- Applies a per-clock PWM brightness mask before driving the board LEDs.
- Sits between the divider and the LED pins; fully synchronous to the fast clock.

Parameters:
- NUM_LEDS, 8, number of LED outputs; must be >= 2.
- PWM_BITS, 4, width of the brightness input and the PWM counter.

Ports:
- clk  input  1  fast system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- step_in  input  1  slow divided clock from the clock divider; treated as asynchronous data.
- enable  input  1  1 = pattern advances and LEDs are driven; 0 = pattern frozen and LEDs dark.
- mode  input  2  00 BLINK, 01 SHIFT, 10 COUNT, 11 HOLD.
- brightness  input  PWM_BITS  PWM duty code.
- pattern  output  NUM_LEDS  current pattern before the PWM mask (registered).
- led  output  NUM_LEDS  pattern ANDed with the PWM mask (registered).
- step_tick  output  1  one-cycle pulse marking the cycle after each accepted step.

Behaviour:

Reset:
- Asynchronous and active-high; clears every register immediately.
- Reset values: sync flops s1/s2/s3 = 0, pattern = 0, led = 0, step_tick = 0, pos = 0, dir = up, mode_q = 00, pwm_cnt = 0.

Edge detect:
- Each cycle: s1 <= step_in, s2 <= s1, s3 <= s2.
- step_edge = s2 & ~s3 (combinational).
- If step_in is high before clock edge e1, step_edge is true during the cycle after e2, and the pattern updates at e3.
- step_tick is registered: step_tick <= accepted step, so it is high for exactly one cycle after e3.
- The synchronizer runs regardless of enable.

Accepted step:
- A step is accepted when step_edge & enable & (mode == mode_q).
- With enable = 0, steps are discarded, pattern holds, and led = 0.
- Re-enabling never replays a missed edge.

Mode change:
- mode_q <= mode every cycle.
- When mode != mode_q, the pattern reinitialises on that edge, and a coincident step_edge is dropped.
- Reinit values: BLINK -> 0; SHIFT -> 1 with pos = 0, dir = up; COUNT -> 0; HOLD -> pattern unchanged.

Modes (on an accepted step):
- BLINK: pattern <= ~pattern, alternating all-zeros and all-ones.
- SHIFT: one-hot bounce, pattern = 1 << pos.
  - dir up: pos + 1; on reaching NUM_LEDS-1, dir flips to down.
  - dir down: pos - 1; on reaching 0, dir flips to up.
  - No LED repeats at the ends. For NUM_LEDS = 8 the sequence is 0,1,...,7,6,...,0,1.
- COUNT: pattern <= pattern + 1, modulo 2^NUM_LEDS; all-ones wraps to 0.
- HOLD: pattern unchanged; step_tick still pulses on each accepted step.

PWM:
- pwm_cnt increments every clk and wraps from 2^PWM_BITS-1 to 0.
- on_mask = (brightness == all-ones) ? 1 : (pwm_cnt < brightness).
- led <= enable ? (pattern & {NUM_LEDS{on_mask}}) : 0, so led is one cycle behind pattern.
- brightness = 0 gives LEDs always off.
- brightness = all-ones gives 100% duty.
- Other codes give brightness/2^PWM_BITS duty.
- brightness may change at any time; it takes effect at the next clock.

Reset mid-operation:
- Asserting rst clears all state asynchronously, with no step or tick emitted.
- If step_in is already high at release, the synchronizer sees a rising edge and exactly one step is accepted 3 cycles after release (documented, intended).

Test Plan (NUM_LEDS = 8, PWM_BITS = 4):
1. Reset/latency
   - Stimulus: hold rst, release; mode = 00, enable = 1, brightness = 15; step_in rises once and stays high for 20 cycles.
   - Required: pattern = 0x00 through reset; pattern = 0xFF at edge 3 after step_in rises; step_tick high exactly one cycle; no further change while step_in stays high.
2. SHIFT bounce
   - Stimulus: mode = 01; apply 16 step_in rising edges.
   - Required: pattern sequence 0x01, 0x02, ..., 0x80, 0x40, ..., 0x01, 0x02; 0x80 and 0x01 never repeat consecutively.
3. COUNT wrap
   - Stimulus: mode = 10; apply 257 steps.
   - Required: pattern reaches 0xFF at step 255, 0x00 at step 256, 0x01 at step 257.
4. PWM duty
   - Stimulus: pattern = 0xFF (BLINK after one step); measure led[0] high count per 16 cycles.
   - Required: brightness 0 -> 0; 4 -> 4; 15 -> 16; led == 0 whenever enable = 0.
5. Mode change vs step
   - Stimulus: in COUNT with pattern = 0x05, change mode to 01 in the same cycle as step_edge.
   - Required: pattern = 0x01, pos = 0, no step_tick; the next step gives 0x02.
6. Enable/reset mid-run
   - Stimulus: deassert enable across 3 steps; then assert rst mid-SHIFT at pattern 0x10.
   - Required: pattern frozen and no step_tick while disabled; on rst, pattern/led/step_tick = 0 immediately, without waiting for a clock edge.
